writeback_arbiter: RTL and testbench

Merges results from the single-cycle ALU path and the variable-latency memory/load path onto the register file's single write port. Each source uses a valid/ready handshake. Memory results are buffered in a small FIFO. The block also keeps a pending-write scoreboard, which decode uses for hazard stalls. It sits between the execute/memory stages and the register file, and drives that file's dataIn/writeSelect/writeEnable inputs directly.

---
 rtl/writeback_arbiter.sv | 146 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

// ============================================================================
// Module   : writeback_arbiter
// Function : Merges ALU and buffered memory results onto the single register
//            file write port and tracks outstanding writes for decode.
//            Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
   parameter int DATA_WIDTH     = `DATA_WIDTH,
   parameter int REGADDR_WIDTH  = `REGADDR_WIDTH,
   parameter int MEM_FIFO_DEPTH = 4,
   parameter int STARVE_LIMIT   = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     aluValid,
   input  logic [REGADDR_WIDTH-1:0] aluDest,
   input  logic [DATA_WIDTH-1:0]    aluResult,
   output logic                     aluReady,
   input  logic                     memValid,
   input  logic [REGADDR_WIDTH-1:0] memDest,
   input  logic [DATA_WIDTH-1:0]    memResult,
   output logic                     memReady,
   input  logic                     issueEnable,
   input  logic [REGADDR_WIDTH-1:0] issueDest,
   output logic [DATA_WIDTH-1:0]    regWriteData,
   output logic [REGADDR_WIDTH-1:0] regWriteSelect,
   output logic                     regWriteEnable,
   output logic [31:0]              pendingMask
);

   localparam int                 c_PTR_W = (MEM_FIFO_DEPTH < 2) ? 1 : $clog2(MEM_FIFO_DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(MEM_FIFO_DEPTH);

   logic [DATA_WIDTH-1:0]    r_fifo_data [MEM_FIFO_DEPTH];
   logic [REGADDR_WIDTH-1:0] r_fifo_dest [MEM_FIFO_DEPTH];
   logic [c_PTR_W-1:0]       r_wr_ptr;
   logic [c_PTR_W-1:0]       r_rd_ptr;
   logic [c_CNT_W-1:0]       r_count;

   logic                     w_fifo_full;
   logic                     w_fifo_nonempty;
   logic                     w_starve_force;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_grant_alu;
   logic [DATA_WIDTH-1:0]    w_win_data;
   logic [REGADDR_WIDTH-1:0] w_win_dest;
   logic [31:0]              w_set;
   logic [31:0]              w_clear;

   assign w_fifo_full     = (r_count == c_FULL);
   assign w_fifo_nonempty = (r_count != '0);

   assign memReady = !reset && !w_fifo_full;
   assign aluReady = !reset && !(w_fifo_nonempty && w_starve_force);

   // The FIFO head wins when the ALU is idle or the head has waited too long.
   assign w_pop       = !reset && w_fifo_nonempty && (!aluValid || w_starve_force);
   assign w_grant_alu = !w_pop && aluValid && aluReady;
   assign w_push      = memValid && memReady;

   assign w_win_data = w_pop ? r_fifo_data[r_rd_ptr] : aluResult;
   assign w_win_dest = w_pop ? r_fifo_dest[r_rd_ptr] : aluDest;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= memResult;
         r_fifo_dest[r_wr_ptr] <= memDest;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int                 c_STV_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);

   logic [c_STV_W-1:0] r_starve_cnt;

   always_ff @(posedge clk) begin
      if (reset || !w_fifo_nonempty || w_pop) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != c_STV_MAX) begin
         r_starve_cnt <= r_starve_cnt + c_STV_W'(1);
      end
   end

   assign w_starve_force = (r_starve_cnt == c_STV_MAX);
`else
   assign w_starve_force = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         regWriteData   <= '0;
         regWriteSelect <= '0;
         regWriteEnable <= 1'b0;
      end else if (w_pop || w_grant_alu) begin
         regWriteData   <= w_win_data;
         regWriteSelect <= w_win_dest;
         regWriteEnable <= (w_win_dest != '0);
      end else begin
         regWriteEnable <= 1'b0;
      end
   end

   // Clear follows the register file capture; a same-edge set takes priority.
   assign w_clear = regWriteEnable ? (32'd1 << regWriteSelect) : 32'd0;
   assign w_set   = (issueEnable && (issueDest != '0)) ? (32'd1 << issueDest) : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         pendingMask <= '0;
      end else begin
         pendingMask <= ((pendingMask & ~w_clear) | w_set) & ~32'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none

// ============================================================================
// Module   : tb_writeback_arbiter
// Function : Self-checking bench for writeback_arbiter (reference model with
//            write scoreboard, vector table and directed corner sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 3;
`ifdef WB_STARVE_GUARD_EN
   localparam bit C_GUARD = 1'b1;
`else
   localparam bit C_GUARD = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  ad;
      logic [31:0] ar;
      logic        mv;
      logic [4:0]  md;
      logic [31:0] mr;
      logic        ie;
      logic [4:0]  id;
      logic        exp_we;
      logic [4:0]  exp_sel;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        aluValid;
   logic [4:0]  aluDest;
   logic [31:0] aluResult;
   logic        aluReady;
   logic        memValid;
   logic [4:0]  memDest;
   logic [31:0] memResult;
   logic        memReady;
   logic        issueEnable;
   logic [4:0]  issueDest;
   logic [31:0] regWriteData;
   logic [4:0]  regWriteSelect;
   logic        regWriteEnable;
   logic [31:0] pendingMask;

   int checks   = 0;
   int failures = 0;

   wr_t         m_fifo[$];
   wr_t         exp_q[$];
   logic        m_we   = 1'b0;
   logic [4:0]  m_sel  = '0;
   logic [31:0] m_data = '0;
   logic [31:0] m_pend = '0;
   int          m_cnt  = 0;

   writeback_arbiter #(
      .DATA_WIDTH    (32),
      .REGADDR_WIDTH (5),
      .MEM_FIFO_DEPTH(DEPTH),
      .STARVE_LIMIT  (LIMIT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .aluValid      (aluValid),
      .aluDest       (aluDest),
      .aluResult     (aluResult),
      .aluReady      (aluReady),
      .memValid      (memValid),
      .memDest       (memDest),
      .memResult     (memResult),
      .memReady      (memReady),
      .issueEnable   (issueEnable),
      .issueDest     (issueDest),
      .regWriteData  (regWriteData),
      .regWriteSelect(regWriteSelect),
      .regWriteEnable(regWriteEnable),
      .pendingMask   (pendingMask)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check ready at the negedge, advance the model
   // across the rising edge, then compare registered outputs.
   task automatic cycle(input logic r, input logic av, input logic [4:0] ad, input logic [31:0] ar,
                        input logic mv, input logic [4:0] md, input logic [31:0] mr,
                        input logic ie, input logic [4:0] id);
      wr_t  w;
      logic ne, frc, exp_ar, exp_mr, g_mem, g_alu;
      reset = r; aluValid = av; aluDest = ad; aluResult = ar;
      memValid = mv; memDest = md; memResult = mr;
      issueEnable = ie; issueDest = id;
      @(negedge clk);
      ne     = (m_fifo.size() != 0);
      frc    = C_GUARD && (m_cnt == LIMIT);
      exp_ar = !r && !(ne && frc);
      exp_mr = !r && (m_fifo.size() < DEPTH);
      check("alu_ready", 32'(aluReady), 32'(exp_ar));
      check("mem_ready", 32'(memReady), 32'(exp_mr));
      @(posedge clk);
      if (r) begin
         m_fifo.delete();
         m_we = 1'b0; m_sel = '0; m_data = '0; m_pend = '0; m_cnt = 0;
      end else begin
         g_mem = ne && (!av || frc);
         g_alu = !g_mem && av && exp_ar;
         if (m_we) m_pend[m_sel] = 1'b0;
         if (ie && id != 5'd0) m_pend[id] = 1'b1;
         if (C_GUARD) m_cnt = (!ne || g_mem) ? 0 : ((m_cnt < LIMIT) ? m_cnt + 1 : m_cnt);
         w = '{dest: ad, data: ar};
         if (g_mem) w = m_fifo.pop_front();
         if (mv && exp_mr) m_fifo.push_back('{dest: md, data: mr});
         if (g_mem || g_alu) begin
            m_sel  = w.dest;
            m_data = w.data;
            m_we   = (w.dest != 5'd0);
            if (m_we) exp_q.push_back(w);
         end else begin
            m_we = 1'b0;
         end
      end
      #1;
      check("write_enable", 32'(regWriteEnable), 32'(m_we));
      if (m_we) begin
         w = exp_q.pop_front();
         check("write_select", 32'(regWriteSelect), 32'(w.dest));
         check("write_data", regWriteData, w.data);
      end else begin
         check("hold_select", 32'(regWriteSelect), 32'(m_sel));
         check("hold_data", regWriteData, m_data);
      end
      check("pending_mask", pendingMask, m_pend);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   vec_t tbl[12];
   logic exp_ar_starve;
   logic [4:0] exp_sel_starve;

   initial begin
      reset = 1'b1; aluValid = 0; aluDest = 0; aluResult = 0;
      memValid = 0; memDest = 0; memResult = 0; issueEnable = 0; issueDest = 0;

      // Reset held with both sources valid
      cycle(1, 1, 5'd9, 32'h99, 1, 5'd8, 32'h88, 1, 5'd6);
      cycle(1, 1, 5'd9, 32'h99, 1, 5'd8, 32'h88, 1, 5'd6);
      check("reset_we", 32'(regWriteEnable), 32'd0);
      check("reset_data", regWriteData, 32'd0);
      check("reset_pending", pendingMask, 32'd0);
      check("reset_alu_ready", 32'(aluReady), 32'd0);
      idle(1);

      // ALU path
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd5);
      check("alu_pend_set", 32'(pendingMask[5]), 32'd1);
      cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      check("alu_we", 32'(regWriteEnable), 32'd1);
      check("alu_sel", 32'(regWriteSelect), 32'd5);
      check("alu_data", regWriteData, 32'hDEADBEEF);
      idle(1);
      check("alu_pend_clr", 32'(pendingMask[5]), 32'd0);

      // x0 write is dropped
      cycle(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      check("x0_we", 32'(regWriteEnable), 32'd0);
      check("x0_pend", 32'(pendingMask[0]), 32'd0);

      // Set/clear collision on r7
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
      cycle(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
      check("collision_pend", 32'(pendingMask[7]), 32'd1);
      cycle(0, 1, 5'd7, 32'h78, 0, 0, 0, 0, 0);
      idle(1);
      check("collision_clr", 32'(pendingMask[7]), 32'd0);

      // Same-cycle contention
      cycle(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0);
      check("cont_first", 32'(regWriteSelect), 32'd3);
      idle(1);
      check("cont_second", 32'(regWriteSelect), 32'd4);
      check("cont_second_data", regWriteData, 32'h22);

      // Fill the FIFO while the ALU holds the port
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 5'd20, 32'h200 + 32'(i), 1, 5'(21 + i), 32'h300 + 32'(i), 0, 0);
         if (i == 2) check("fifo_not_full", 32'(memReady), 32'd1);
      end
      check("fifo_full", 32'(memReady), 32'd0);
      idle(5);

      // Starvation of a queued memory result
      cycle(0, 1, 5'd25, 32'h25, 1, 5'd26, 32'h26, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 5'd25, 32'h25, 0, 0, 0, 0, 0);
      exp_ar_starve  = !C_GUARD;
      exp_sel_starve = C_GUARD ? 5'd26 : 5'd25;
      check("starve_alu_ready", 32'(aluReady), 32'(exp_ar_starve));
      cycle(0, 1, 5'd25, 32'h25, 0, 0, 0, 0, 0);
      check("starve_commit", 32'(regWriteSelect), 32'(exp_sel_starve));
      idle(1);
      check("starve_final", 32'(regWriteSelect), 32'd26);
      idle(1);

      // Vector table: {rst, av, ad, ar, mv, md, mr, ie, id, exp_we, exp_sel}
      tbl[0]  = '{0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 1, 5'd12, 1, 5'd10};
      tbl[1]  = '{0, 0, 5'd0,  32'h0,  1, 5'd12, 32'hB1, 0, 5'd0,  1, 5'd11};
      tbl[2]  = '{0, 1, 5'd13, 32'hA1, 0, 5'd0,  32'h0,  0, 5'd0,  1, 5'd13};
      tbl[3]  = '{0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  1, 5'd12};
      tbl[4]  = '{0, 1, 5'd0,  32'h5,  0, 5'd0,  32'h0,  0, 5'd0,  0, 5'd0};
      tbl[5]  = '{0, 0, 5'd0,  32'h0,  1, 5'd0,  32'h6,  0, 5'd0,  0, 5'd0};
      tbl[6]  = '{0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  0, 5'd0};
      tbl[7]  = '{1, 1, 5'd9,  32'h9,  1, 5'd9,  32'h9,  0, 5'd0,  0, 5'd0};
      tbl[8]  = '{0, 0, 5'd0,  32'h0,  1, 5'd14, 32'hB2, 1, 5'd14, 0, 5'd0};
      tbl[9]  = '{1, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  0, 5'd0};
      tbl[10] = '{0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  0, 5'd0};
      tbl[11] = '{0, 1, 5'd15, 32'hA2, 0, 5'd0,  32'h0,  1, 5'd15, 1, 5'd15};
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].ar, tbl[i].mv, tbl[i].md, tbl[i].mr,
               tbl[i].ie, tbl[i].id);
         check($sformatf("vec%0d_we", i), 32'(regWriteEnable), 32'(tbl[i].exp_we));
         check($sformatf("vec%0d_sel", i), 32'(regWriteSelect), 32'(tbl[i].exp_sel));
      end
      check("vec_reset_pend", 32'(pendingMask[14]), 32'd0);

      // Random mixed traffic against the model
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
